// File: rtl/snake_body_ring_ctrl.sv
// Ring-buffer controller for snake body segments held in an external simple dual-port RAM.
// Head pushes append; tail pops and indexed scans share the single registered read port.
module snake_body_ring_ctrl #(
  parameter int SIZE  = 16,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            push_valid,
  input  logic [SIZE-1:0] push_data,
  output logic            push_ready,
  input  logic            pop_req,
  output logic            pop_grant,
  input  logic            scan_req,
  input  logic [AW-1:0]   scan_index,
  output logic            scan_grant,
  output logic [SIZE-1:0] rd_data,
  output logic            rd_data_valid,
  output logic            rd_is_pop,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            full,
  output logic [AW-1:0]   ram_waddr,
  output logic [SIZE-1:0] ram_write_data,
  output logic            ram_write_en,
  output logic [AW-1:0]   ram_raddr,
  input  logic [SIZE-1:0] ram_read_data
);

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count_q;
  logic          push_fire;
  logic          scan_in_range;

  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  // push_ready depends on occupancy only, never on a same-cycle pop.
  assign push_ready = ~full;

  // Handshake: push transfers when push_valid & push_ready; pop/scan transfer when
  // their grant is high. Grants and writes are held low while in reset or clear.
  assign push_fire     = rst_n & push_valid & ~full & ~clear;
  assign scan_in_range = (CW'(scan_index) < count_q);
  assign pop_grant     = rst_n & pop_req & ~empty & ~clear;
  assign scan_grant    = rst_n & scan_req & ~pop_grant & ~clear & scan_in_range;

  assign ram_waddr      = head;
  assign ram_write_data = push_data;
  assign ram_write_en   = push_fire;

  // Reads only touch indices below count and writes only land at head when not full,
  // so read and write addresses never collide in the same cycle.
  always_comb begin
    ram_raddr = tail;
    if (scan_grant) begin
      ram_raddr = tail + scan_index;
    end
  end

  assign rd_data = ram_read_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head          <= '0;
      tail          <= '0;
      count_q       <= '0;
      rd_data_valid <= 1'b0;
      rd_is_pop     <= 1'b0;
    end else begin
      rd_data_valid <= pop_grant | scan_grant;
      rd_is_pop     <= pop_grant;
      if (clear) begin
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
      end else begin
        if (push_fire) begin
          head <= head + 1'b1;
        end
        if (pop_grant) begin
          tail <= tail + 1'b1;
        end
        case ({push_fire, pop_grant})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snake_body_ring_ctrl.sv
// Directed bench for snake_body_ring_ctrl at DEPTH=4 with a behavioural 1-cycle-read RAM.
module tb_snake_body_ring_ctrl;

  localparam int SIZE  = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CW    = 3;

  logic            clk;
  logic            rst_n;
  logic            clear;
  logic            push_valid;
  logic [SIZE-1:0] push_data;
  logic            push_ready;
  logic            pop_req;
  logic            pop_grant;
  logic            scan_req;
  logic [AW-1:0]   scan_index;
  logic            scan_grant;
  logic [SIZE-1:0] rd_data;
  logic            rd_data_valid;
  logic            rd_is_pop;
  logic [CW-1:0]   count;
  logic            empty;
  logic            full;
  logic [AW-1:0]   ram_waddr;
  logic [SIZE-1:0] ram_write_data;
  logic            ram_write_en;
  logic [AW-1:0]   ram_raddr;
  logic [SIZE-1:0] ram_read_data;

  int n_checks;
  int n_fail;

  snake_body_ring_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_req(pop_req), .pop_grant(pop_grant),
    .scan_req(scan_req), .scan_index(scan_index), .scan_grant(scan_grant),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_is_pop(rd_is_pop),
    .count(count), .empty(empty), .full(full),
    .ram_waddr(ram_waddr), .ram_write_data(ram_write_data), .ram_write_en(ram_write_en),
    .ram_raddr(ram_raddr), .ram_read_data(ram_read_data)
  );

  // Clock / reset block and RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [SIZE-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_waddr] <= ram_write_data;
    ram_read_data <= mem[ram_raddr];
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear      = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    pop_req    = 1'b0;
    scan_req   = 1'b0;
    scan_index = '0;
  endtask

  task automatic push_one(input logic [SIZE-1:0] d);
    push_valid = 1'b1;
    push_data  = d;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #1;
    push_valid = 1'b1;
    pop_req    = 1'b1;
    scan_req   = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: empty=%b full=%b want 1 0", empty, full); end
    n_checks++; if (rd_data_valid !== 1'b0 || rd_is_pop !== 1'b0) begin n_fail++; $display("FAIL reset_rd: valid=%b is_pop=%b want 0 0", rd_data_valid, rd_is_pop); end
    n_checks++; if (ram_write_en !== 1'b0 || pop_grant !== 1'b0 || scan_grant !== 1'b0) begin n_fail++; $display("FAIL reset_gates: we=%b pop=%b scan=%b want 0 0 0", ram_write_en, pop_grant, scan_grant); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (count !== 3'd0 || ram_raddr !== 2'd0) begin n_fail++; $display("FAIL reset_release: count=%0d raddr=%0d want 0 0", count, ram_raddr); end
  endtask

  task automatic test_push_pop();
    push_valid = 1'b1;
    push_data  = 16'h0101;
    #1;
    n_checks++; if (ram_write_en !== 1'b1 || ram_waddr !== 2'd0 || ram_write_data !== 16'h0101) begin n_fail++; $display("FAIL push_write: we=%b addr=%0d data=%h want 1 0 0101", ram_write_en, ram_waddr, ram_write_data); end
    tick();
    push_data = 16'h0202;
    tick();
    push_data = 16'h0303;
    tick();
    push_valid = 1'b0;
    #1;
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL push_count: got %0d want 3", count); end
    pop_req = 1'b1;
    #1;
    n_checks++; if (pop_grant !== 1'b1 || ram_raddr !== 2'd0) begin n_fail++; $display("FAIL pop_grant: grant=%b raddr=%0d want 1 0", pop_grant, ram_raddr); end
    tick();
    pop_req = 1'b0;
    #1;
    n_checks++; if (rd_data_valid !== 1'b1 || rd_is_pop !== 1'b1 || rd_data !== 16'h0101) begin n_fail++; $display("FAIL pop_data: valid=%b is_pop=%b data=%h want 1 1 0101", rd_data_valid, rd_is_pop, rd_data); end
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL pop_count: got %0d want 2", count); end
  endtask

  task automatic test_full();
    do_clear();
    for (int i = 0; i < 4; i++) push_one(16'h1111 * SIZE'(i + 1));
    #1;
    n_checks++; if (full !== 1'b1 || push_ready !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL full_flags: full=%b ready=%b count=%0d want 1 0 4", full, push_ready, count); end
    push_valid = 1'b1;
    push_data  = 16'h5555;
    #1;
    n_checks++; if (ram_write_en !== 1'b0) begin n_fail++; $display("FAIL full_no_write: we=%b want 0", ram_write_en); end
    tick();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_hold: count=%0d want 4", count); end
    pop_req = 1'b1;
    #1;
    n_checks++; if (pop_grant !== 1'b1 || ram_write_en !== 1'b0 || push_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_push: pop=%b we=%b ready=%b want 1 0 0", pop_grant, ram_write_en, push_ready); end
    tick();
    idle();
    #1;
    n_checks++; if (count !== 3'd3 || rd_data !== 16'h1111) begin n_fail++; $display("FAIL full_after: count=%0d data=%h want 3 1111", count, rd_data); end
  endtask

  task automatic test_wrap_scan();
    logic [SIZE-1:0] exp_v [3];
    exp_v[0] = 16'h00AA;
    exp_v[1] = 16'h00BB;
    exp_v[2] = 16'h00CC;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      push_one(16'h0A00 + SIZE'(i));
      pop_req = 1'b1;
      tick();
      pop_req = 1'b0;
      #1;
      n_checks++; if (rd_data !== 16'h0A00 + SIZE'(i) || rd_is_pop !== 1'b1) begin n_fail++; $display("FAIL wrap_pop%0d: data=%h is_pop=%b want %h 1", i, rd_data, rd_is_pop, 16'h0A00 + SIZE'(i)); end
    end
    for (int i = 0; i < 3; i++) push_one(exp_v[i]);
    scan_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      scan_index = AW'(i);
      #1;
      if (i < 3) begin
        n_checks++; if (scan_grant !== 1'b1 || ram_raddr !== AW'(2 + i)) begin n_fail++; $display("FAIL scan_grant%0d: grant=%b raddr=%0d want 1 %0d", i, scan_grant, ram_raddr, (2 + i) % 4); end
      end else begin
        n_checks++; if (scan_grant !== 1'b0) begin n_fail++; $display("FAIL scan_out_of_range: grant=%b want 0", scan_grant); end
      end
      if (i > 0) begin
        n_checks++; if (rd_data_valid !== 1'b1 || rd_is_pop !== 1'b0 || rd_data !== exp_v[i-1]) begin n_fail++; $display("FAIL scan_data%0d: valid=%b is_pop=%b data=%h want 1 0 %h", i - 1, rd_data_valid, rd_is_pop, rd_data, exp_v[i-1]); end
      end
      tick();
    end
    scan_req = 1'b0;
    #1;
    n_checks++; if (rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL scan_oor_valid: valid=%b want 0", rd_data_valid); end
  endtask

  task automatic test_back_to_back();
    pop_req    = 1'b1;
    scan_req   = 1'b1;
    scan_index = 2'd0;
    #1;
    n_checks++; if (pop_grant !== 1'b1 || scan_grant !== 1'b0) begin n_fail++; $display("FAIL arb_priority: pop=%b scan=%b want 1 0", pop_grant, scan_grant); end
    tick();
    pop_req = 1'b0;
    #1;
    n_checks++; if (scan_grant !== 1'b1 || ram_raddr !== 2'd3) begin n_fail++; $display("FAIL arb_scan_next: grant=%b raddr=%0d want 1 3", scan_grant, ram_raddr); end
    n_checks++; if (rd_data_valid !== 1'b1 || rd_is_pop !== 1'b1 || rd_data !== 16'h00AA) begin n_fail++; $display("FAIL b2b_first: valid=%b is_pop=%b data=%h want 1 1 00aa", rd_data_valid, rd_is_pop, rd_data); end
    tick();
    scan_req = 1'b0;
    #1;
    n_checks++; if (rd_data_valid !== 1'b1 || rd_is_pop !== 1'b0 || rd_data !== 16'h00BB) begin n_fail++; $display("FAIL b2b_second: valid=%b is_pop=%b data=%h want 1 0 00bb", rd_data_valid, rd_is_pop, rd_data); end
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", count); end
  endtask

  task automatic test_empty_push();
    do_clear();
    pop_req    = 1'b1;
    push_valid = 1'b1;
    push_data  = 16'h5A5A;
    #1;
    n_checks++; if (pop_grant !== 1'b0 || ram_write_en !== 1'b1) begin n_fail++; $display("FAIL empty_pop: pop=%b we=%b want 0 1", pop_grant, ram_write_en); end
    tick();
    push_valid = 1'b0;
    #1;
    n_checks++; if (count !== 3'd1 || pop_grant !== 1'b1 || rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL empty_next: count=%0d pop=%b valid=%b want 1 1 0", count, pop_grant, rd_data_valid); end
    tick();
    pop_req = 1'b0;
    #1;
    n_checks++; if (rd_data !== 16'h5A5A || rd_is_pop !== 1'b1 || empty !== 1'b1) begin n_fail++; $display("FAIL empty_result: data=%h is_pop=%b empty=%b want 5a5a 1 1", rd_data, rd_is_pop, empty); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) push_one(16'h0C01 + SIZE'(i));
    scan_req   = 1'b1;
    scan_index = 2'd1;
    #1;
    n_checks++; if (scan_grant !== 1'b1 || ram_raddr !== 2'd2) begin n_fail++; $display("FAIL clear_pre_scan: grant=%b raddr=%0d want 1 2", scan_grant, ram_raddr); end
    tick();
    clear      = 1'b1;
    pop_req    = 1'b1;
    push_valid = 1'b1;
    push_data  = 16'hDEAD;
    #1;
    n_checks++; if (pop_grant !== 1'b0 || scan_grant !== 1'b0 || ram_write_en !== 1'b0) begin n_fail++; $display("FAIL clear_suppress: pop=%b scan=%b we=%b want 0 0 0", pop_grant, scan_grant, ram_write_en); end
    n_checks++; if (rd_data_valid !== 1'b1 || rd_is_pop !== 1'b0 || rd_data !== 16'h0C02) begin n_fail++; $display("FAIL clear_inflight: valid=%b is_pop=%b data=%h want 1 0 0c02", rd_data_valid, rd_is_pop, rd_data); end
    tick();
    clear      = 1'b0;
    push_valid = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || empty !== 1'b1 || rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL clear_after: count=%0d empty=%b valid=%b want 0 1 0", count, empty, rd_data_valid); end
    n_checks++; if (pop_grant !== 1'b0 || scan_grant !== 1'b0) begin n_fail++; $display("FAIL clear_no_grants: pop=%b scan=%b want 0 0", pop_grant, scan_grant); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_pop();
    push_one(16'h7777);
    pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    #1;
    n_checks++; if (rd_data_valid !== 1'b1 || rd_data !== 16'h7777) begin n_fail++; $display("FAIL mid_pop_valid: valid=%b data=%h want 1 7777", rd_data_valid, rd_data); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (rd_data_valid !== 1'b0 || rd_is_pop !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL mid_pop_reset: valid=%b is_pop=%b empty=%b want 0 0 1", rd_data_valid, rd_is_pop, empty); end
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_push_pop();
    test_full();
    test_wrap_scan();
    test_back_to_back();
    test_empty_push();
    test_clear();
    test_reset_mid_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
